// File: rtl/adder_reg_bank_pkg.sv
// Shared constants for the adder register bank: register offsets, bit positions,
// default address limit, sequencer states and the byte-strobe merge helper.
package adder_reg_bank_pkg;

    localparam logic [7:0] CTRL_OFF   = 8'h00;
    localparam logic [7:0] STATUS_OFF = 8'h04;
    localparam logic [7:0] OPA_OFF    = 8'h08;
    localparam logic [7:0] OPB_OFF    = 8'h0C;
    localparam logic [7:0] RESULT_OFF = 8'h10;

    localparam logic [2:0] IDX_CTRL   = CTRL_OFF[4:2];
    localparam logic [2:0] IDX_STATUS = STATUS_OFF[4:2];
    localparam logic [2:0] IDX_OPA    = OPA_OFF[4:2];
    localparam logic [2:0] IDX_OPB    = OPB_OFF[4:2];
    localparam logic [2:0] IDX_RESULT = RESULT_OFF[4:2];

    localparam int START_BIT = 0;
    localparam int IEN_BIT   = 1;
    localparam int BUSY_BIT  = 0;
    localparam int DONE_BIT  = 1;
    localparam int CARRY_BIT = 2;

    localparam logic [31:0] ADDR_LIMIT_DEF = 32'h14;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_reg_bank_if.sv
// Write/read port bundle between the AXI4-Lite slave (master side) and the register bank.
// Handshake: a write is accepted on the rising edge where i_en_amba_write=1; reads are
// combinational from i_addr_rc. dbg_state exposes the sequencer state.
interface adder_reg_bank_if;
    import adder_reg_bank_pkg::*;

    logic        i_en_amba_write;
    logic [31:0] i_data_wc;
    logic [31:0] i_addr_wc;
    logic [3:0]  i_strb;
    logic [31:0] i_addr_rc;
    logic [31:0] o_data_rc;
    logic        o_is_busy;
    logic        o_irq;
    state_t      dbg_state;

    modport master (
        output i_en_amba_write, i_data_wc, i_addr_wc, i_strb, i_addr_rc,
        input  o_data_rc, o_is_busy, o_irq, dbg_state
    );

    modport slave (
        input  i_en_amba_write, i_data_wc, i_addr_wc, i_strb, i_addr_rc,
        output o_data_rc, o_is_busy, o_irq, dbg_state
    );

endinterface

// File: rtl/adder_serial_core.sv
// Lane-serial 32-bit adder: LANE_W bits per cycle, partial sums shifted in from the MSB.
// done pulses on the completion edge with sum/carry_out valid in that same cycle.
module adder_serial_core
    import adder_reg_bank_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
    output logic        carry_out,
    output state_t      state
);

    localparam int NLANES = 32 / LANE_W;
    localparam int CNT_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NLANES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       acc_q, acc_d;
    logic [LANE_W:0]   lane_sum;
    logic [31:0]       lane_ext;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        done     = 1'b0;
        lane_sum = {1'b0, a_q[LANE_W-1:0]} + {1'b0, b_q[LANE_W-1:0]}
                 + {{LANE_W{1'b0}}, carry_q};
        lane_ext = 32'(lane_sum[LANE_W-1:0]);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    a_d     = op_a;
                    b_d     = op_b;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    acc_d   = '0;
                end
            end
            ST_CALC: begin
                a_d     = a_q >> LANE_W;
                b_d     = b_q >> LANE_W;
                acc_d   = (acc_q >> LANE_W) | (lane_ext << (32 - LANE_W));
                carry_d = lane_sum[LANE_W];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // acc_d holds the complete sum only on the done cycle; the top samples it then.
    assign busy      = (state_q == ST_CALC);
    assign sum       = acc_d;
    assign carry_out = lane_sum[LANE_W];
    assign state     = state_q;

endmodule

// File: rtl/adder_reg_bank.sv
// Register bank with bus decode, strobe merge and read mux around adder_serial_core.
// Optional macro ADDER_REG_BANK_IRQ_EN enables o_irq = DONE & IEN (registered).
module adder_reg_bank
    import adder_reg_bank_pkg::*;
#(
    parameter int          LANE_W     = 8,
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
    input  logic             ACLK,
    input  logic             ARSTn,
    adder_reg_bank_if.slave  bus
);

    logic        ien_q, ien_d;
    logic        done_q, done_d;
    logic        carry_q, carry_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] result_q, result_d;

    logic        wr_hit, rd_hit, wr_ok, start;
    logic [2:0]  wr_idx, rd_idx;
    logic        core_busy, core_done, core_carry;
    logic [31:0] core_sum;
    state_t      core_state;

    assign wr_hit = (bus.i_addr_wc[31:8] == 24'd0) && ({24'd0, bus.i_addr_wc[7:0]} < ADDR_LIMIT);
    assign rd_hit = (bus.i_addr_rc[31:8] == 24'd0) && ({24'd0, bus.i_addr_rc[7:0]} < ADDR_LIMIT);
    assign wr_idx = bus.i_addr_wc[4:2];
    assign rd_idx = bus.i_addr_rc[4:2];

    // Writes while busy are dropped entirely; the slave reports SLVERR for them.
    assign wr_ok = bus.i_en_amba_write && wr_hit && !core_busy;
    assign start = wr_ok && (wr_idx == IDX_CTRL) && bus.i_strb[0] && bus.i_data_wc[START_BIT];

    always_comb begin
        ien_d    = ien_q;
        done_d   = done_q;
        carry_d  = carry_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        if (wr_ok) begin
            case (wr_idx)
                IDX_CTRL:   if (bus.i_strb[0]) ien_d = bus.i_data_wc[IEN_BIT];
                IDX_STATUS: if (bus.i_strb[0] && bus.i_data_wc[DONE_BIT]) done_d = 1'b0;
                IDX_OPA:    op_a_d = merge_bytes(op_a_q, bus.i_data_wc, bus.i_strb);
                IDX_OPB:    op_b_d = merge_bytes(op_b_q, bus.i_data_wc, bus.i_strb);
                default:    ;
            endcase
        end
        if (start) done_d = 1'b0;
        // Completion has priority over a same-edge DONE clear.
        if (core_done) begin
            done_d   = 1'b1;
            result_d = core_sum;
            carry_d  = core_carry;
        end
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            ien_q    <= 1'b0;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
        end else begin
            ien_q    <= ien_d;
            done_q   <= done_d;
            carry_q  <= carry_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
        end
    end

    adder_serial_core #(.LANE_W(LANE_W)) u_core (
        .clk       (ACLK),
        .rst_n     (ARSTn),
        .start     (start),
        .op_a      (op_a_q),
        .op_b      (op_b_q),
        .busy      (core_busy),
        .done      (core_done),
        .sum       (core_sum),
        .carry_out (core_carry),
        .state     (core_state)
    );

    always_comb begin
        bus.o_data_rc = '0;
        if (rd_hit) begin
            case (rd_idx)
                IDX_CTRL:   bus.o_data_rc[IEN_BIT] = ien_q;
                IDX_STATUS: begin
                    bus.o_data_rc[BUSY_BIT]  = core_busy;
                    bus.o_data_rc[DONE_BIT]  = done_q;
                    bus.o_data_rc[CARRY_BIT] = carry_q;
                end
                IDX_OPA:    bus.o_data_rc = op_a_q;
                IDX_OPB:    bus.o_data_rc = op_b_q;
                IDX_RESULT: bus.o_data_rc = result_q;
                default:    bus.o_data_rc = '0;
            endcase
        end
    end

    assign bus.o_is_busy = core_busy;
    assign bus.dbg_state = core_state;

`ifdef ADDER_REG_BANK_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = done_d & ien_d;

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign bus.o_irq = irq_q;
`else
    assign bus.o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_adder_reg_bank.sv
// Self-checking bench for adder_reg_bank: randomized register traffic and additions
// compared against a register-level model that uses plain 33-bit addition.
module tb_adder_reg_bank;
    import adder_reg_bank_pkg::*;

    localparam int NLANES_EXP = 4;

    logic ACLK;
    logic ARSTn;

    adder_reg_bank_if bus();

    adder_reg_bank dut (
        .ACLK  (ACLK),
        .ARSTn (ARSTn),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic        m_ien, m_done, m_carry;
    logic [31:0] m_a, m_b, m_result;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_irq();
`ifdef ADDER_REG_BANK_IRQ_EN
        return m_done & m_ien;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic busy);
        if (addr[31:8] != 24'd0 || addr[7:0] >= 8'h14) return 32'd0;
        case (addr[4:2])
            3'd0:    return {30'd0, m_ien, 1'b0};
            3'd1:    return {29'd0, m_carry, m_done, busy};
            3'd2:    return m_a;
            3'd3:    return m_b;
            3'd4:    return m_result;
            default: return 32'd0;
        endcase
    endfunction

    // Idle-time write without START.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (addr[31:8] != 24'd0 || addr[7:0] >= 8'h14) return;
        case (addr[4:2])
            3'd0: if (strb[0]) m_ien = data[1];
            3'd1: if (strb[0] && data[1]) m_done = 1'b0;
            3'd2: for (int i = 0; i < 4; i++) if (strb[i]) m_a[8*i +: 8] = data[8*i +: 8];
            3'd3: for (int i = 0; i < 4; i++) if (strb[i]) m_b[8*i +: 8] = data[8*i +: 8];
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_ien = 0; m_done = 0; m_carry = 0; m_a = 0; m_b = 0; m_result = 0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge ACLK);
        bus.i_en_amba_write = 1'b1;
        bus.i_addr_wc       = addr;
        bus.i_data_wc       = data;
        bus.i_strb          = strb;
        @(negedge ACLK);
        bus.i_en_amba_write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.i_addr_rc = addr;
        #1;
        data = bus.o_data_rc;
    endtask

    task automatic run_add(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctrl, input string name);
        logic [31:0] rd;
        logic [31:0] old_result;
        int cycles;
        bus_write({24'd0, OPA_OFF}, a, 4'hF);
        bus_write({24'd0, OPB_OFF}, b, 4'hF);
        m_a = a; m_b = b;
        old_result = m_result;
        bus_write({24'd0, CTRL_OFF}, {30'd0, ctrl[1], 1'b1}, 4'h1);
        m_ien = ctrl[1]; m_done = 1'b0;
        bus_read({24'd0, RESULT_OFF}, rd);
        n_tests++;
        if (rd !== old_result) begin
            n_fail++; $display("FAIL %s_result_hold: got %h exp %h", name, rd, old_result);
        end
        n_tests++;
        if (bus.o_irq !== 1'b0) begin
            n_fail++; $display("FAIL %s_irq_during_calc: got %b exp 0", name, bus.o_irq);
        end
        cycles = 0;
        while (bus.o_is_busy === 1'b1 && cycles < 20) begin
            cycles++;
            @(negedge ACLK);
        end
        n_tests++;
        if (cycles != NLANES_EXP) begin
            n_fail++; $display("FAIL %s_busy_cycles: got %0d exp %0d", name, cycles, NLANES_EXP);
        end
        {m_carry, m_result} = {1'b0, a} + {1'b0, b};
        m_done = 1'b1;
        bus_read({24'd0, RESULT_OFF}, rd);
        n_tests++;
        if (rd !== m_result) begin
            n_fail++; $display("FAIL %s_result: got %h exp %h", name, rd, m_result);
        end
        bus_read({24'd0, STATUS_OFF}, rd);
        n_tests++;
        if (rd !== model_read({24'd0, STATUS_OFF}, 1'b0)) begin
            n_fail++; $display("FAIL %s_status: got %h exp %h", name, rd, model_read({24'd0, STATUS_OFF}, 1'b0));
        end
        n_tests++;
        if (bus.o_irq !== exp_irq()) begin
            n_fail++; $display("FAIL %s_irq: got %b exp %b", name, bus.o_irq, exp_irq());
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        ARSTn = 1'b0;
        repeat (3) @(negedge ACLK);
        ARSTn = 1'b1;
        model_reset();
        for (int off = 0; off <= 'h14; off += 4) begin
            bus_read(32'(off), rd);
            n_tests++;
            if (rd !== 32'd0) begin
                n_fail++; $display("FAIL reset_read_%0h: got %h exp 0", off, rd);
            end
        end
        n_tests++;
        if (bus.o_is_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.o_is_busy);
        end
        n_tests++;
        if (bus.o_irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b exp 0", bus.o_irq);
        end
        n_tests++;
        if (bus.dbg_state !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d exp %0d", bus.dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_add_directed();
        logic [31:0] rd;
        run_add(32'h12345678, 32'h11111111, 2'b00, "add_basic");
        n_tests++;
        if (m_result !== 32'h23456789 || m_carry !== 1'b0) begin
            n_fail++; $display("FAIL add_basic_model: got %h/%b exp 23456789/0", m_result, m_carry);
        end
        run_add(32'hFFFFFFFF, 32'h00000001, 2'b00, "add_wrap");
        bus_read({24'd0, RESULT_OFF}, rd);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL add_wrap_zero: got %h exp 00000000", rd);
        end
        bus_write({24'd0, STATUS_OFF}, 32'h2, 4'h1);
        m_done = 1'b0;
        bus_read({24'd0, STATUS_OFF}, rd);
        n_tests++;
        if (rd !== 32'h4) begin
            n_fail++; $display("FAIL done_clear: got %h exp 00000004", rd);
        end
    endtask

    task automatic test_strobe_and_misses();
        logic [31:0] rd;
        logic [31:0] miss_addr[3];
        bus_write({24'd0, OPA_OFF}, 32'h0, 4'hF);
        model_write({24'd0, OPA_OFF}, 32'h0, 4'hF);
        bus_write({24'd0, OPA_OFF}, 32'hAABBCCDD, 4'b0101);
        model_write({24'd0, OPA_OFF}, 32'hAABBCCDD, 4'b0101);
        bus_read({24'd0, OPA_OFF}, rd);
        n_tests++;
        if (rd !== 32'h00BB00DD) begin
            n_fail++; $display("FAIL strobe_merge: got %h exp 00BB00DD", rd);
        end
        miss_addr[0] = 32'h20; miss_addr[1] = 32'h100; miss_addr[2] = 32'h14;
        for (int k = 0; k < 3; k++) begin
            bus_write(miss_addr[k], $urandom | 32'h3, 4'hF);
            bus_read(miss_addr[k], rd);
            n_tests++;
            if (rd !== 32'd0) begin
                n_fail++; $display("FAIL miss_read_%0h: got %h exp 0", miss_addr[k], rd);
            end
        end
        for (int off = 0; off < 'h14; off += 4) begin
            bus_read(32'(off), rd);
            n_tests++;
            if (rd !== model_read(32'(off), 1'b0)) begin
                n_fail++; $display("FAIL miss_nochange_%0h: got %h exp %h", off, rd, model_read(32'(off), 1'b0));
            end
        end
    endtask

    task automatic test_random_regs();
        logic [31:0] rd, addr, data;
        logic [3:0]  strb;
        int sel;
        for (int it = 0; it < 24; it++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                5:       addr = 32'h14;
                6:       addr = 32'h18;
                7:       addr = 32'h20;
                8:       addr = 32'h100 + 32'($urandom_range(0, 'h13));
                9:       addr = 32'h8000_0008;
                default: addr = 32'(sel * 4 + $urandom_range(0, 3));
            endcase
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if (addr[31:8] == 24'd0 && addr[7:0] < 8'h14 && addr[4:2] == 3'd0) data[0] = 1'b0;
            bus_write(addr, data, strb);
            model_write(addr, data, strb);
            bus_read(addr, rd);
            n_tests++;
            if (rd !== model_read(addr, 1'b0)) begin
                n_fail++; $display("FAIL rand_reg_%0d addr %h: got %h exp %h", it, addr, rd, model_read(addr, 1'b0));
            end
            n_tests++;
            if (bus.o_irq !== exp_irq()) begin
                n_fail++; $display("FAIL rand_irq_%0d: got %b exp %b", it, bus.o_irq, exp_irq());
            end
        end
    endtask

    task automatic test_random_add();
        for (int it = 0; it < 6; it++) begin
            run_add($urandom, $urandom, 2'b00, "add_rand");
        end
    endtask

    task automatic test_back_to_back_busy_write();
        logic [31:0] rd, a, b;
        int cycles;
        a = $urandom; b = $urandom;
        bus_write({24'd0, OPA_OFF}, a, 4'hF);
        bus_write({24'd0, OPB_OFF}, b, 4'hF);
        m_a = a; m_b = b;
        bus_write({24'd0, CTRL_OFF}, 32'h1, 4'h1);
        m_ien = 1'b0; m_done = 1'b0;
        bus_write({24'd0, OPB_OFF}, 32'h5, 4'hF);
        bus_write({24'd0, CTRL_OFF}, 32'h3, 4'h1);
        cycles = 0;
        while (bus.o_is_busy === 1'b1 && cycles < 20) begin
            cycles++;
            @(negedge ACLK);
        end
        n_tests++;
        if (cycles >= 20) begin
            n_fail++; $display("FAIL busy_write_timeout: got %0d cycles exp < 20", cycles);
        end
        {m_carry, m_result} = {1'b0, a} + {1'b0, b};
        m_done = 1'b1;
        repeat (2) @(negedge ACLK);
        n_tests++;
        if (bus.o_is_busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_write_restart: got %b exp 0", bus.o_is_busy);
        end
        for (int off = 0; off < 'h14; off += 4) begin
            bus_read(32'(off), rd);
            n_tests++;
            if (rd !== model_read(32'(off), 1'b0)) begin
                n_fail++; $display("FAIL busy_write_%0h: got %h exp %h", off, rd, model_read(32'(off), 1'b0));
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] rd;
        bus_write({24'd0, OPA_OFF}, 32'h0F0F_0F0F, 4'hF);
        bus_write({24'd0, OPB_OFF}, 32'h1010_1010, 4'hF);
        bus_write({24'd0, CTRL_OFF}, 32'h1, 4'h1);
        @(negedge ACLK);
        n_tests++;
        if (bus.o_is_busy !== 1'b1 || bus.dbg_state !== ST_CALC) begin
            n_fail++; $display("FAIL mid_busy: got %b/%0d exp 1/%0d", bus.o_is_busy, bus.dbg_state, ST_CALC);
        end
        ARSTn = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (bus.o_is_busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_busy: got %b exp 0", bus.o_is_busy);
        end
        bus_read({24'd0, RESULT_OFF}, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset_result: got %h exp 0", rd);
        end
        bus_read({24'd0, OPA_OFF}, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset_opa: got %h exp 0", rd);
        end
        @(negedge ACLK);
        ARSTn = 1'b1;
        repeat (NLANES_EXP + 2) @(negedge ACLK);
        bus_read({24'd0, STATUS_OFF}, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset_status: got %h exp 0", rd);
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        run_add($urandom, $urandom, 2'b10, "irq_run1");
`ifdef ADDER_REG_BANK_IRQ_EN
        n_tests++;
        if (bus.o_irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_set: got %b exp 1", bus.o_irq);
        end
`endif
        bus_write({24'd0, STATUS_OFF}, 32'h2, 4'h1);
        m_done = 1'b0;
        n_tests++;
        if (bus.o_irq !== exp_irq()) begin
            n_fail++; $display("FAIL irq_done_clear: got %b exp %b", bus.o_irq, exp_irq());
        end
        run_add($urandom, $urandom, 2'b10, "irq_run2");
        bus_write({24'd0, CTRL_OFF}, 32'h0, 4'h1);
        m_ien = 1'b0;
        n_tests++;
        if (bus.o_irq !== exp_irq()) begin
            n_fail++; $display("FAIL irq_ien_clear: got %b exp %b", bus.o_irq, exp_irq());
        end
        bus_read({24'd0, CTRL_OFF}, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL ien_readback: got %h exp 0", rd);
        end
    endtask

    initial begin
        ARSTn               = 1'b0;
        bus.i_en_amba_write = 1'b0;
        bus.i_data_wc       = '0;
        bus.i_addr_wc       = '0;
        bus.i_strb          = '0;
        bus.i_addr_rc       = '0;
        model_reset();

        test_reset();
        test_add_directed();
        test_strobe_and_misses();
        test_random_regs();
        test_random_add();
        test_back_to_back_busy_write();
        test_reset_mid_calc();
        test_irq();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_reg_bank.md
Name: adder_reg_bank

Overview:
- Register bank plus multi-cycle adder sitting directly downstream of the AXI4-Lite slave.
- Consumes the slave's write-enable, data, address and strobe outputs, and its read address.
- Returns read data and the busy flag that the slave uses to answer SLVERR.
- Computes a 32-bit sum LANE_W bits per cycle, driven by a START bit written over the bus.

Parameters:
- LANE_W, 8: bits added per CALC cycle; must divide 32. NLANES = 32/LANE_W.
- ADDR_LIMIT, 'h14: first unmapped byte offset; must match the slave's range check.

Ports:
- ACLK  in  1: clock, rising edge.
- ARSTn  in  1: asynchronous active-low reset.
- i_en_amba_write  in  1: one-cycle write strobe from the slave.
- i_data_wc  in  32: write data.
- i_addr_wc  in  32: write byte address.
- i_strb  in  4: byte-lane enables for the write.
- i_addr_rc  in  32: read byte address.
- o_data_rc  out  32: read data, combinational from i_addr_rc.
- o_is_busy  out  1: high while the adder is computing.
- o_irq  out  1: interrupt, level-sensitive.

Behaviour:
- Address decode: hit only when addr[31:8]==0 and addr[7:0]<ADDR_LIMIT. Word index is addr[4:2]; addr[1:0] is ignored. Misses: reads return 0, writes are dropped.
- Register map:
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IEN (RW).
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (write-1-to-clear); bit2 CARRY (RO).
  - 0x08 OP_A (RW).
  - 0x0C OP_B (RW).
  - 0x10 RESULT (RO).
  - Unused bits read 0.
- Writes apply only to byte lanes with i_strb[n]=1. START and DONE-clear sit in byte 0 and need i_strb[0].
- Reset values: all registers 0, FSM in IDLE, o_is_busy=0, o_irq=0, o_data_rc follows decode (0 at address 0).
- FSM has two states, IDLE and CALC:
  - IDLE→CALC on an edge with i_en_amba_write=1, CTRL hit, i_strb[0]=1 and data bit0=1. On that edge: latch OP_A/OP_B into working shift registers, clear the lane counter and carry, clear DONE.
  - In CALC, each cycle adds the low LANE_W bits of both operands plus the carry, shifts the partial sum in from the MSB side, and increments the counter.
  - CALC→IDLE on the edge where counter==NLANES-1. On that edge: RESULT ← full sum, CARRY ← carry-out, DONE ← 1.
- o_is_busy is registered; it is high for exactly NLANES cycles (4 by default), starting the cycle after the START edge. RESULT and CARRY update only on the completion edge, so reads during CALC return previous values.
- Any write while BUSY (any register) is dropped, including START, and leaves no state change. The slave already answers SLVERR in that case.
- A DONE write-1-to-clear on the same edge DONE is set: set wins.
- START with IEN set in the same write: IEN is applied and the computation starts.
- Arithmetic is modulo 2^32; carry-out goes to CARRY. Example: 0xFFFFFFFF+1 → RESULT 0, CARRY 1.
- ARSTn asserted mid-CALC: immediately returns to IDLE, partial sum discarded, all registers at reset values.

Optional Feature:
- Macro ADDER_REG_BANK_IRQ_EN.
- Defined: o_irq = DONE & IEN, registered-level. It drops on the edge DONE is cleared, or when IEN is written 0.
- Undefined: o_irq tied to 0; IEN bit stays RW storage with no effect.

Decomposition:
- Shared package adder_reg_bank_pkg holds:
  - Register offset constants (CTRL/STATUS/OP_A/OP_B/RESULT).
  - Bit-position constants (START, IEN, BUSY, DONE, CARRY).
  - The ADDR_LIMIT default.
  - The IDLE/CALC state enum.
- One sub-module, adder_serial_core. It holds the FSM, lane counter, carry and shift registers. Interface: start, op_a, op_b in; busy, done-pulse, sum, carry_out out.
- The top holds decode, strobe merge, register storage and read mux.

Test Plan:
- Reset, then read every address 0x00–0x10 and 0x14 → all 0; o_is_busy=0, o_irq=0.
- Write OP_A=0x12345678, OP_B=0x11111111, CTRL=0x1 → BUSY high exactly 4 cycles; RESULT=0x23456789, CARRY=0, DONE=1.
- OP_A=0xFFFFFFFF, OP_B=0x00000001, start → RESULT=0x00000000, CARRY=1. Then write STATUS=0x2 → DONE=0.
- Write OP_A=0xAABBCCDD with i_strb=4'b0101 over 0 → OP_A=0x00BB00DD. Write to 0x20 and 0x100 → no register changes.
- Write OP_B=0x5 during BUSY → OP_B unchanged and sum uses the old value. Assert ARSTn low mid-CALC → BUSY=0, RESULT=0 immediately.
- With ADDER_REG_BANK_IRQ_EN: CTRL=0x3 → o_irq=1 at completion; STATUS write 0x2 → o_irq=0. Without the macro → o_irq stays 0.
